onehot_dec_seq: RTL

- Parametrised, registered binary-to-one-hot decoder. Successor to the fixed 3-to-8 combinational decoder.
- Adds a valid/ready input handshake, a held output register with its own valid/ready, and an auto-scan mode.
- In scan mode the block walks the one-hot output across all lines with a programmable dwell.
- Used as a line-select / strobe generator feeding muxes, LED/display scanners and chip-select fabrics.

---
 rtl/onehot_dec_pkg.sv | 17 +
 rtl/onehot_dec_seq_if.sv | 28 ++
 rtl/onehot_dec_seq_dwell_counter.sv | 31 +++
 rtl/onehot_dec_seq.sv | 125 ++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
package onehot_dec_pkg;

  localparam int MAX_SEL_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } dec_state_t;

  // Widest one-hot pattern; callers size-cast down to their own line count.
  function automatic logic [63:0] onehot64(input logic [MAX_SEL_W-1:0] idx);
    return 64'd1 << idx;
  endfunction

endpackage

// File: rtl/onehot_dec_seq_if.sv
// Handshake, configuration and output bundle of onehot_dec_seq.
interface onehot_dec_seq_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
);
  localparam int OUT_W = 1 << SEL_W;

  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   sel;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic               scan_wrap;

  modport master (
    output mode, dwell, in_valid, sel, out_ready,
    input  in_ready, out, out_valid, scan_wrap
  );

  modport slave (
    input  mode, dwell, in_valid, sel, out_ready,
    output in_ready, out, out_valid, scan_wrap
  );

endinterface

// File: rtl/onehot_dec_seq_dwell_counter.sv
// Dwell down-counter: loaded with the dwell value at each line start, flags
// terminal count when it reaches zero so a line lasts dwell+1 cycles.
module dwell_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/onehot_dec_seq.sv
// Registered binary-to-one-hot decoder with valid/ready handshake and auto-scan.
// Build option ONEHOT_DEC_ACTIVE_LOW_EN: drive out as the inverted one-hot code.
//
// state | meaning
// IDLE  | no valid code on out, waiting for sel or mode=1
// HOLD  | out holds 1<<sel until the consumer accepts it
// SCAN  | out walks line 0..OUT_W-1, each held dwell+1 cycles
module onehot_dec_seq
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  onehot_dec_seq_if.slave  bus
);

  localparam int OUT_W = 1 << SEL_W;

  dec_state_t       r_state;
  logic [OUT_W-1:0] r_onehot;
  logic             r_out_valid;
  logic             r_scan_wrap;
  logic [SEL_W-1:0] r_idx;

  logic             w_in_ready;
  logic             w_enter_scan;
  logic             w_tc;
  logic             w_load;
  logic             w_clr;
  logic [OUT_W-1:0] w_sel_line;
  logic [OUT_W-1:0] w_next_line;
  logic [SEL_W-1:0] w_idx_nxt;

  assign w_in_ready  = (r_state != SCAN) && (!r_out_valid || bus.out_ready);
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_sel_line  = OUT_W'(onehot64(MAX_SEL_W'(bus.sel)));
  assign w_next_line = OUT_W'(onehot64(MAX_SEL_W'(w_idx_nxt)));

  // A pending HOLD code must be accepted before scan may take over the output.
  assign w_enter_scan = bus.mode &&
                        ((r_state == IDLE) || ((r_state == HOLD) && bus.out_ready));
  assign w_load = w_enter_scan || ((r_state == SCAN) && bus.mode && w_tc);
  assign w_clr  = (r_state == SCAN) && !bus.mode;

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (bus.dwell),
    .i_en       (r_state == SCAN),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_onehot    <= '0;
      r_out_valid <= 1'b0;
      r_scan_wrap <= 1'b0;
      r_idx       <= '0;
    end else begin
      r_scan_wrap <= 1'b0;
      if (w_enter_scan) begin
        r_state     <= SCAN;
        r_idx       <= '0;
        r_onehot    <= OUT_W'(1);
        r_out_valid <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.in_valid && w_in_ready) begin
              r_state     <= HOLD;
              r_onehot    <= w_sel_line;
              r_out_valid <= 1'b1;
            end
          end
          HOLD: begin
            if (bus.out_ready) begin
              if (bus.in_valid) begin
                r_onehot <= w_sel_line;
              end else begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
`ifdef ONEHOT_DEC_ACTIVE_LOW_EN
                r_onehot    <= '0;
`endif
              end
            end
          end
          SCAN: begin
            if (!bus.mode) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_idx       <= '0;
`ifdef ONEHOT_DEC_ACTIVE_LOW_EN
              r_onehot    <= '0;
`endif
            end else if (w_tc) begin
              r_idx       <= w_idx_nxt;
              r_onehot    <= w_next_line;
              r_scan_wrap <= &r_idx;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.scan_wrap = r_scan_wrap;
`ifdef ONEHOT_DEC_ACTIVE_LOW_EN
  assign bus.out = ~r_onehot;
`else
  assign bus.out = r_onehot;
`endif

endmodule
